// File: rtl/bcd_pkg.sv
// Shared definitions for the binary/packed-BCD to display-BCD converter.
package bcd_pkg;

    // Converter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits per BCD digit.
    localparam int DIGIT_W = 4;

    // Display code shown on overflow or malformed BCD input.
    localparam logic [11:0] FALLBACK_DEFAULT = 12'h035;

    // Digits at or above this value get +3 before the next left shift.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_dabble_cell.sv
// One double-dabble correction cell: adds 3 to a digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
module bcd_dabble_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Add-3 correction; wraps in 4 bits for out-of-range digits.
    always_comb begin
        if (digit >= ADD3_THRESH) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary / packed-BCD to display-BCD converter with a
// start/ready/valid handshake. Binary input is converted one bit per clock
// (shift-and-add-3); packed-BCD input is validated in a single cycle.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3,
    parameter logic [DIGIT_W*DIGITS-1:0] FALLBACK = (DIGIT_W*DIGITS)'(FALLBACK_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [IN_W-1:0]           din,
    output logic                      ready,
    output logic                      valid,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      err
);

    localparam int RES_W = DIGIT_W * DIGITS;
    localparam int NIB_N = (IN_W + DIGIT_W - 1) / DIGIT_W;
    localparam int PAD_W = DIGIT_W * NIB_N;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t             state_r, state_next;
    logic [CNT_W-1:0]   cnt_r, cnt_next;
    logic [RES_W-1:0]   work_r, work_next;
    logic               ovf_r, ovf_next;
    logic [IN_W-1:0]    din_r, din_next;
    logic               mode_r, mode_next;
    logic [RES_W-1:0]   bcd_r, bcd_next;
    logic               err_r, err_next;
    logic               valid_r, valid_next;
    logic               ready_r, ready_next;

    logic [RES_W-1:0]   dab_s;
    logic [PAD_W-1:0]   din_pad_s;
    logic [RES_W-1:0]   bcd_res_s;
    logic               invalid_s;

    assign ready = ready_r;
    assign valid = valid_r;
    assign bcd   = bcd_r;
    assign err   = err_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
        bcd_dabble_cell u_cell (
            .digit    (work_r[DIGIT_W*g +: DIGIT_W]),
            .adjusted (dab_s[DIGIT_W*g +: DIGIT_W])
        );
    end

    // Packed-BCD check: every nibble must be a decimal digit, and nibbles
    // beyond the display width must be zero.
    always_comb begin
        din_pad_s = PAD_W'(din_r);
        bcd_res_s = RES_W'(din_pad_s);
        invalid_s = 1'b0;
        for (int i = 0; i < NIB_N; i++) begin
            if (din_pad_s[DIGIT_W*i +: DIGIT_W] > 4'd9) begin
                invalid_s = 1'b1;
            end else if ((i >= DIGITS) && (din_pad_s[DIGIT_W*i +: DIGIT_W] != 4'd0)) begin
                invalid_s = 1'b1;
            end else begin
                invalid_s = invalid_s;
            end
        end
    end

    // Next-state and datapath update for the IDLE/CONV/DONE sequencer.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        work_next  = work_r;
        ovf_next   = ovf_r;
        din_next   = din_r;
        mode_next  = mode_r;
        bcd_next   = bcd_r;
        err_next   = err_r;
        valid_next = 1'b0;
        ready_next = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && ready_r) begin
                    din_next   = din;
                    mode_next  = mode;
                    work_next  = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = mode ? CNT_W'(1) : CNT_W'(IN_W);
                    state_next = ST_CONV;
                    ready_next = 1'b0;
                end else begin
                    // Also the cycle after valid: ready returns one cycle late.
                    ready_next = 1'b1;
                end
            end
            ST_CONV: begin
                cnt_next = cnt_r - CNT_W'(1);
                if (mode_r) begin
                    work_next = bcd_res_s;
                    ovf_next  = invalid_s;
                end else begin
                    // A 1 leaving the top digit means the value reached 10^DIGITS.
                    work_next = {dab_s[RES_W-2:0], din_r[IN_W-1]};
                    ovf_next  = ovf_r | dab_s[RES_W-1];
                    din_next  = din_r << 1'b1;
                end
                if (cnt_r <= CNT_W'(1)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CONV;
                end
            end
            ST_DONE: begin
                bcd_next   = ovf_r ? FALLBACK : work_r;
                err_next   = ovf_r;
                valid_next = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            work_r  <= '0;
            ovf_r   <= 1'b0;
            din_r   <= '0;
            mode_r  <= 1'b0;
            bcd_r   <= '0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            work_r  <= work_next;
            ovf_r   <= ovf_next;
            din_r   <= din_next;
            mode_r  <= mode_next;
            bcd_r   <= bcd_next;
            err_r   <= err_next;
            valid_r <= valid_next;
            ready_r <= ready_next;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd: three parameterisations
// (8-bit/3-digit default, 8-bit/2-digit, 12-bit/4-digit exhaustive sweep).
module tb_bin_to_bcd;

    logic clk;
    logic rst;

    logic        start_a, mode_a, ready_a, valid_a, err_a;
    logic [7:0]  din_a;
    logic [11:0] bcd_a;

    logic        start_b, mode_b, ready_b, valid_b, err_b;
    logic [7:0]  din_b;
    logic [7:0]  bcd_b;

    logic        start_c, mode_c, ready_c, valid_c, err_c;
    logic [11:0] din_c;
    logic [15:0] bcd_c;

    int checks   = 0;
    int failures = 0;

    bin_to_bcd u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .din(din_a),
        .ready(ready_a), .valid(valid_a), .bcd(bcd_a), .err(err_a)
    );

    bin_to_bcd #(.IN_W(8), .DIGITS(2), .FALLBACK(8'h35)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .din(din_b),
        .ready(ready_b), .valid(valid_b), .bcd(bcd_b), .err(err_b)
    );

    bin_to_bcd #(.IN_W(12), .DIGITS(4), .FALLBACK(16'h0035)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .din(din_c),
        .ready(ready_c), .valid(valid_c), .bcd(bcd_c), .err(err_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int inst);
        case (inst)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    function automatic logic vld(input int inst);
        case (inst)
            0:       return valid_a;
            1:       return valid_b;
            default: return valid_c;
        endcase
    endfunction

    function automatic logic [15:0] res(input int inst);
        case (inst)
            0:       return {4'h0, bcd_a};
            1:       return {8'h00, bcd_b};
            default: return bcd_c;
        endcase
    endfunction

    function automatic logic erf(input int inst);
        case (inst)
            0:       return err_a;
            1:       return err_b;
            default: return err_c;
        endcase
    endfunction

    task automatic set_in(input int inst, input logic s, input logic m, input logic [11:0] d);
        case (inst)
            0: begin start_a = s; mode_a = m; din_a = d[7:0]; end
            1: begin start_b = s; mode_b = m; din_b = d[7:0]; end
            default: begin start_c = s; mode_c = m; din_c = d; end
        endcase
    endtask

    // One transaction: waits for ready, pulses start, counts edges to valid,
    // captures the result and checks that valid drops the following cycle.
    task automatic run(input int inst, input logic m, input logic [11:0] d,
                       output logic [15:0] b, output logic e, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!rdy(inst) && n < 40) begin
            @(negedge clk);
            n++;
        end
        set_in(inst, 1'b1, m, d);
        @(posedge clk);
        #1;
        set_in(inst, 1'b0, 1'b0, 12'h000);
        lat = 0;
        while (!vld(inst) && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        b = res(inst);
        e = erf(inst);
        @(posedge clk);
        #1;
        check("valid_single_pulse", {31'd0, vld(inst)}, 32'd0);
    endtask

    initial begin
        logic [15:0] b;
        logic        e;
        logic [15:0] exp_bcd;
        int          lat;
        int          nv;

        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 12'h000);
        set_in(1, 1'b0, 1'b0, 12'h000);
        set_in(2, 1'b0, 1'b0, 12'h000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'd0, ready_a}, 32'd1);
        check("reset_valid", {31'd0, valid_a}, 32'd0);
        check("reset_bcd",   {20'd0, bcd_a},   32'h000);
        check("reset_err",   {31'd0, err_a},   32'd0);

        // Default instance, binary mode.
        run(0, 1'b0, 12'd255, b, e, lat);
        check("a_bin255_bcd", {16'd0, b}, 32'h255);
        check("a_bin255_err", {31'd0, e}, 32'd0);
        check("a_bin255_lat", lat, 32'd9);
        run(0, 1'b0, 12'd0, b, e, lat);
        check("a_bin0_bcd", {16'd0, b}, 32'h000);
        check("a_bin0_err", {31'd0, e}, 32'd0);
        run(0, 1'b0, 12'd7, b, e, lat);
        check("a_bin7_bcd", {16'd0, b}, 32'h007);

        // Two-digit instance: last exact value and overflow to fallback.
        run(1, 1'b0, 12'd99, b, e, lat);
        check("b_bin99_bcd", {16'd0, b}, 32'h99);
        check("b_bin99_err", {31'd0, e}, 32'd0);
        run(1, 1'b0, 12'd100, b, e, lat);
        check("b_bin100_bcd", {16'd0, b}, 32'h35);
        check("b_bin100_err", {31'd0, e}, 32'd1);
        run(1, 1'b0, 12'd255, b, e, lat);
        check("b_bin255_bcd", {16'd0, b}, 32'h35);
        check("b_bin255_err", {31'd0, e}, 32'd1);
        check("b_bin255_lat", lat, 32'd9);

        // Packed-BCD mode on the default instance.
        run(0, 1'b1, 12'h047, b, e, lat);
        check("a_bcd47_bcd", {16'd0, b}, 32'h047);
        check("a_bcd47_err", {31'd0, e}, 32'd0);
        check("a_bcd47_lat", lat, 32'd2);
        run(0, 1'b1, 12'h04A, b, e, lat);
        check("a_bcd4A_bcd", {16'd0, b}, 32'h035);
        check("a_bcd4A_err", {31'd0, e}, 32'd1);
        run(0, 1'b1, 12'h090, b, e, lat);
        check("a_bcd90_bcd", {16'd0, b}, 32'h090);
        check("a_bcd90_err", {31'd0, e}, 32'd0);
        // Upper nibble beyond two digits must be zero on the 2-digit instance.
        run(1, 1'b1, 12'h099, b, e, lat);
        check("b_bcd99_bcd", {16'd0, b}, 32'h99);

        // Start pulsed mid-conversion with another operand is ignored.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 12'd200);
        @(posedge clk);
        #1;
        nv = 0;
        b = 16'h0000;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                set_in(0, 1'b1, 1'b0, 12'd77);
            end else begin
                set_in(0, 1'b0, 1'b0, 12'd0);
            end
            @(posedge clk);
            #1;
            if (valid_a) begin
                nv++;
                b = {4'h0, bcd_a};
            end
        end
        check("busy_start_nvalid", nv, 32'd1);
        check("busy_start_bcd", {16'd0, b}, 32'h200);

        // Reset in the middle of a binary conversion.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 12'd50);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 12'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        check("abort_valid", {31'd0, valid_a}, 32'd0);
        check("abort_bcd",   {20'd0, bcd_a},   32'h000);
        check("abort_err",   {31'd0, err_a},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_a) nv++;
        end
        check("abort_no_valid", nv, 32'd0);
        run(0, 1'b0, 12'd123, b, e, lat);
        check("after_abort_bcd", {16'd0, b}, 32'h123);
        check("after_abort_lat", lat, 32'd9);

        // Exhaustive 12-bit sweep on the 4-digit instance.
        for (int v = 0; v < 4096; v++) begin
            exp_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            run(2, 1'b0, 12'(v), b, e, lat);
            check("sweep_bcd", {16'd0, b}, {16'd0, exp_bcd});
            check("sweep_err", {31'd0, e}, 32'd0);
            check("sweep_lat", lat, 32'd13);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
